// File: rtl/intr_gateway_arb_pkg.sv
// Shared types and constants for the interrupt gateway/arbiter:
// gateway state encoding {ip, ia}, the "no interrupt" ID and the ID width helper.
package intr_gateway_pkg;

   localparam int unsigned ID_NONE = 0;

   // Bit 1 is the pending flag, bit 0 the in-service flag.
   typedef enum logic [1:0] {
      GW_IDLE    = 2'b00,
      GW_PENDING = 2'b10,
      GW_ACTIVE  = 2'b01
   } gw_state_e;

   function automatic int id_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/intr_gateway_arb_if.sv
// Target-side claim/complete handshake and interrupt request bundle.
interface intr_gateway_arb_if #(
   parameter int IdW = 4
) ();

   logic           claim_i;
   logic [IdW-1:0] claim_id_o;
   logic           complete_i;
   logic [IdW-1:0] complete_id_i;
   logic           irq_o;
   logic [IdW-1:0] irq_id_o;

   modport master (
      output claim_i, complete_i, complete_id_i,
      input  claim_id_o, irq_o, irq_id_o
   );

   modport slave (
      input  claim_i, complete_i, complete_id_i,
      output claim_id_o, irq_o, irq_id_o
   );

endinterface

// File: rtl/intr_gateway_arb_gateway.sv
// Per-source gateway: level/edge event detection and the IDLE/PENDING/ACTIVE machine
// that blocks re-pending while the source is in service.
module intr_gateway
   import intr_gateway_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic src_i,
   input  logic le_i,
   input  logic claim_hit_i,
   input  logic complete_hit_i,
   output logic ip_o
);

   logic      src_d, src_q;
   logic      event_w;
   gw_state_e state_d, state_q;

   always_comb begin
      src_d   = src_i;
      event_w = le_i ? (src_i & ~src_q) : src_i;
      state_d = state_q;
      // Events seen outside IDLE are dropped, including one coinciding with completion.
      case (state_q)
         GW_IDLE:    if (event_w)        state_d = GW_PENDING;
         GW_PENDING: if (claim_hit_i)    state_d = GW_ACTIVE;
         GW_ACTIVE:  if (complete_hit_i) state_d = GW_IDLE;
         default:                        state_d = GW_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q   <= 1'b0;
         state_q <= GW_IDLE;
      end else begin
         src_q   <= src_d;
         state_q <= state_d;
      end
   end

   assign ip_o = (state_q == GW_PENDING);

endmodule

// File: rtl/intr_gateway_arb.sv
// Interrupt gateway array plus registered max-priority arbiter for a single target.
module intr_gateway_arb
   import intr_gateway_pkg::*;
#(
   parameter int N     = 8,
   parameter int PrioW = 2,
   parameter int IdW   = id_width(N)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N-1:0]       src_i,
   input  logic [N-1:0]       le_i,
   input  logic [N-1:0]       ie_i,
   input  logic [N*PrioW-1:0] prio_i,
   input  logic [PrioW-1:0]   threshold_i,
   output logic [N-1:0]       ip_o,
   intr_gateway_arb_if.slave  tgt
);

   logic [N-1:0]     claim_hit;
   logic [N-1:0]     complete_hit;
   logic [IdW-1:0]   irq_id_d, irq_id_q;
   logic             irq_d, irq_q;
   logic [PrioW-1:0] best_prio;

   // ID 0 and IDs above N match no gateway, so such claims/completes fall through.
   for (genvar gi = 0; gi < N; gi++) begin : g_src
      localparam logic [IdW-1:0] SrcId = IdW'(gi + 1);

      assign claim_hit[gi]    = tgt.claim_i    & (tgt.claim_id_o    == SrcId);
      assign complete_hit[gi] = tgt.complete_i & (tgt.complete_id_i == SrcId);

      intr_gateway u_gw (
         .clk_i          (clk_i),
         .rst_i          (rst_i),
         .src_i          (src_i[gi]),
         .le_i           (le_i[gi]),
         .claim_hit_i    (claim_hit[gi]),
         .complete_hit_i (complete_hit[gi]),
         .ip_o           (ip_o[gi])
      );
   end

   // Strict '>' keeps the lowest index on ties; best_prio starts at 0, which no candidate has.
   always_comb begin
      irq_id_d  = IdW'(ID_NONE);
      best_prio = '0;
      for (int k = 0; k < N; k++) begin
         if (ip_o[k] && ie_i[k]
             && (prio_i[k*PrioW +: PrioW] > threshold_i)
             && (prio_i[k*PrioW +: PrioW] > best_prio)) begin
            best_prio = prio_i[k*PrioW +: PrioW];
            irq_id_d  = IdW'(k + 1);
         end
      end
      irq_d = (irq_id_d != IdW'(ID_NONE));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_id_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         irq_id_q <= irq_id_d;
         irq_q    <= irq_d;
      end
   end

   assign tgt.irq_id_o   = irq_id_q;
   assign tgt.irq_o      = irq_q;
   assign tgt.claim_id_o = irq_id_q;

endmodule
